imem_boot_loader: RTL and testbench

- Sits directly upstream of the RV32I single-cycle processor.
- Receives a program image as a byte stream and assembles little-endian 32-bit words.
- Writes each word into the processor's instruction memory write port.
- Holds the processor in reset (cpu_rst_n low) until a complete image with a valid checksum has been loaded.

---
 rtl/imem_boot_loader_if.sv | 67 ++++++
 rtl/imem_boot_loader.sv | 222 ++++++++++++++++++++++
 tb/tb_imem_boot_loader.sv | 275 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/imem_boot_loader_if.sv
// ---------------------------------------------------------------------------
// imem_boot_loader_if
//
// Bundles the byte-stream input, the instruction-memory write port and the
// load status / processor reset outputs of the boot loader.
//
//   slave  modport : the loader's view (consumes bytes, drives memory/status)
//   master modport : the environment's view (supplies bytes, observes writes)
//
// Signals:
//   rx_data    [7:0]            incoming image byte
//   rx_valid                    rx_data valid
//   rx_ready                    loader accepts byte this cycle
//   restart                     one-cycle pulse, leaves DONE/ERROR
//   imem_we                     instruction-memory write strobe
//   imem_addr  [ADDR_WIDTH-1:0] word address for write
//   imem_wdata [31:0]           assembled little-endian word
//   cpu_rst_n                   processor reset, active-low
//   load_done                   image loaded and checksum matched
//   load_error                  checksum mismatch or oversize length
//   word_count [ADDR_WIDTH:0]   words written in current/last load
// ---------------------------------------------------------------------------
interface imem_boot_loader_if #(
   parameter int ADDR_WIDTH = 10
);

   logic [7:0]            rx_data;
   logic                  rx_valid;
   logic                  rx_ready;
   logic                  restart;
   logic                  imem_we;
   logic [ADDR_WIDTH-1:0] imem_addr;
   logic [31:0]           imem_wdata;
   logic                  cpu_rst_n;
   logic                  load_done;
   logic                  load_error;
   logic [ADDR_WIDTH:0]   word_count;

   modport slave (
      input  rx_data,
      input  rx_valid,
      input  restart,
      output rx_ready,
      output imem_we,
      output imem_addr,
      output imem_wdata,
      output cpu_rst_n,
      output load_done,
      output load_error,
      output word_count
   );

   modport master (
      output rx_data,
      output rx_valid,
      output restart,
      input  rx_ready,
      input  imem_we,
      input  imem_addr,
      input  imem_wdata,
      input  cpu_rst_n,
      input  load_done,
      input  load_error,
      input  word_count
   );

endinterface

// File: rtl/imem_boot_loader.sv
// ---------------------------------------------------------------------------
// imem_boot_loader
//
// Receives a framed program image as a byte stream, assembles little-endian
// 32-bit words and writes them into the instruction memory of the RV32I core.
// The core is held in reset (cpu_rst_n low) until a complete image whose
// XOR checksum matches has been loaded.
//
// Frame: SYNC_BYTE, LEN_LO, LEN_HI, N*4 payload bytes (LSB first), CSUM,
// where CSUM is the XOR of the payload bytes only.
//
// Ports:
//   clk  rising-edge system clock
//   rst  asynchronous active-high reset
//   bus  imem_boot_loader_if.slave: rx_data/rx_valid/rx_ready byte stream,
//        restart pulse, imem_we/imem_addr/imem_wdata memory write port,
//        cpu_rst_n, load_done, load_error, word_count status
// ---------------------------------------------------------------------------
module imem_boot_loader #(
   parameter int         ADDR_WIDTH = 10,
   parameter logic [7:0] SYNC_BYTE  = 8'hA5
) (
   input  logic                 clk,
   input  logic                 rst,
   imem_boot_loader_if.slave    bus
);

   localparam int          CW       = ADDR_WIDTH + 1;
   localparam logic [31:0] CAPACITY = 32'd1 << ADDR_WIDTH;

   typedef enum logic [2:0] {
      IDLE,
      LEN0,
      LEN1,
      DATA,
      CSUM,
      DONE,
      ERROR
   } state_t;

   state_t                state;
   state_t                next_state;

   logic                  rx_ready_int;
   logic                  accept;
   logic                  restart_hit;

   logic [7:0]            len_lo;
   logic [15:0]           len;
   logic [15:0]           len_full;
   logic                  len_too_big;
   logic                  last_word;
   logic                  csum_match;

   logic [1:0]            lane;
   logic [23:0]           word_buf;
   logic [7:0]            csum;
   logic [CW-1:0]         word_count_q;

   logic                  imem_we_q;
   logic [ADDR_WIDTH-1:0] imem_addr_q;
   logic [31:0]           imem_wdata_q;
   logic                  cpu_rst_n_q;
   logic                  load_done_q;
   logic                  load_error_q;

   // Decisions shared by the FSM and the datapath. The length bound is
   // compared in 32 bits so any ADDR_WIDTH works against the 16-bit count.
   // The word index is word_count itself, so the last word is the one whose
   // lane 3 arrives when word_count + 1 reaches N.
   assign len_full    = {bus.rx_data, len_lo};
   assign len_too_big = 32'(len_full) > CAPACITY;
   assign last_word   = (32'(word_count_q) + 32'd1) == 32'(len);
   assign csum_match  = (bus.rx_data == csum);
   assign restart_hit = bus.restart && ((state == DONE) || (state == ERROR));

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= next_state;
      end
   end

   // Next-state logic. Every transition except restart is driven by an
   // accepted byte; DONE and ERROR stay put until restart.
   always_comb begin
      next_state = state;
      case (state)
         IDLE: begin
            if (accept && (bus.rx_data == SYNC_BYTE)) begin
               next_state = LEN0;
            end
         end
         LEN0: begin
            if (accept) begin
               next_state = LEN1;
            end
         end
         LEN1: begin
            if (accept) begin
               if (len_too_big) begin
                  next_state = ERROR;
               end else if (len_full == 16'd0) begin
                  next_state = CSUM;
               end else begin
                  next_state = DATA;
               end
            end
         end
         DATA: begin
            if (accept && (lane == 2'd3) && last_word) begin
               next_state = CSUM;
            end
         end
         CSUM: begin
            if (accept) begin
               next_state = csum_match ? DONE : ERROR;
            end
         end
         DONE, ERROR: begin
            if (bus.restart) begin
               next_state = IDLE;
            end
         end
         default: begin
            next_state = IDLE;
         end
      endcase
   end

   // Output logic. The loader never stalls while it is consuming a frame,
   // so rx_ready only depends on the state; it is also forced low while
   // reset is held so no byte is taken during the reset pulse.
   always_comb begin
      rx_ready_int = 1'b0;
      if (!rst) begin
         case (state)
            IDLE, LEN0, LEN1, DATA, CSUM: rx_ready_int = 1'b1;
            default:                      rx_ready_int = 1'b0;
         endcase
      end
      accept = bus.rx_valid && rx_ready_int;
   end

   // Byte datapath: length capture, lane assembly, running checksum and the
   // registered memory write. The write strobe is a one-cycle pulse issued
   // the cycle after lane 3 is taken, and word_count advances with it so it
   // always equals the number of words already written.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         len_lo       <= 8'd0;
         len          <= 16'd0;
         lane         <= 2'd0;
         word_buf     <= 24'd0;
         csum         <= 8'd0;
         word_count_q <= '0;
         imem_we_q    <= 1'b0;
         imem_addr_q  <= '0;
         imem_wdata_q <= 32'd0;
      end else begin
         imem_we_q <= 1'b0;
         if (restart_hit) begin
            lane         <= 2'd0;
            csum         <= 8'd0;
            word_count_q <= '0;
         end else if (accept) begin
            case (state)
               LEN0: begin
                  len_lo <= bus.rx_data;
               end
               LEN1: begin
                  len <= len_full;
               end
               DATA: begin
                  csum <= csum ^ bus.rx_data;
                  lane <= lane + 2'd1;
                  case (lane)
                     2'd0: word_buf[7:0]   <= bus.rx_data;
                     2'd1: word_buf[15:8]  <= bus.rx_data;
                     2'd2: word_buf[23:16] <= bus.rx_data;
                     default: begin
                        imem_we_q    <= 1'b1;
                        imem_addr_q  <= word_count_q[ADDR_WIDTH-1:0];
                        imem_wdata_q <= {bus.rx_data, word_buf};
                        word_count_q <= word_count_q + 1'b1;
                     end
                  endcase
               end
               default: begin
               end
            endcase
         end
      end
   end

   // Status flags are registered from the next state so that cpu_rst_n is
   // a clean flop output and rises exactly one cycle after the matching
   // checksum byte, and falls one cycle after restart.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cpu_rst_n_q  <= 1'b0;
         load_done_q  <= 1'b0;
         load_error_q <= 1'b0;
      end else begin
         cpu_rst_n_q  <= (next_state == DONE);
         load_done_q  <= (next_state == DONE);
         load_error_q <= (next_state == ERROR);
      end
   end

   assign bus.rx_ready   = rx_ready_int;
   assign bus.imem_we    = imem_we_q;
   assign bus.imem_addr  = imem_addr_q;
   assign bus.imem_wdata = imem_wdata_q;
   assign bus.cpu_rst_n  = cpu_rst_n_q;
   assign bus.load_done  = load_done_q;
   assign bus.load_error = load_error_q;
   assign bus.word_count = word_count_q;

endmodule

// File: tb/tb_imem_boot_loader.sv
// ---------------------------------------------------------------------------
// tb_imem_boot_loader
//
// Self-checking bench for imem_boot_loader (ADDR_WIDTH=4, capacity 16 words).
// Frames are held in stim_q; a frame-level parser computes the writes and
// final status the loader must produce, and a negedge monitor records the
// writes the loader actually performs.
// ---------------------------------------------------------------------------
module tb_imem_boot_loader;

   localparam int AW  = 4;
   localparam int CAP = 1 << AW;

   logic clk = 1'b0;
   logic rst;

   imem_boot_loader_if #(.ADDR_WIDTH(AW)) bus ();

   imem_boot_loader #(
      .ADDR_WIDTH (AW),
      .SYNC_BYTE  (8'hA5)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   int          check_count = 0;
   int          pass_count  = 0;

   logic [7:0]  stim_q[$];
   int          got_addr[$];
   logic [31:0] got_data[$];
   logic [31:0] exp_data[$];
   bit          exp_done;
   bit          exp_error;

   // Record every memory write, sampled mid-cycle.
   always @(negedge clk) begin
      if (!rst && bus.imem_we === 1'b1) begin
         got_addr.push_back(int'(bus.imem_addr));
         got_data.push_back(bus.imem_wdata);
      end
   end

   task automatic checkOutput(input string tag, input logic [31:0] actual,
                              input logic [31:0] expected);
      check_count++;
      if (actual === expected) begin
         pass_count++;
      end else begin
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t",
                  tag, actual, expected, $time);
      end
   endtask

   task automatic checkResetValues();
      checkOutput("rst_rx_ready",   32'(bus.rx_ready),   32'd0);
      checkOutput("rst_imem_we",    32'(bus.imem_we),    32'd0);
      checkOutput("rst_imem_addr",  32'(bus.imem_addr),  32'd0);
      checkOutput("rst_imem_wdata", bus.imem_wdata,      32'd0);
      checkOutput("rst_cpu_rst_n",  32'(bus.cpu_rst_n),  32'd0);
      checkOutput("rst_load_done",  32'(bus.load_done),  32'd0);
      checkOutput("rst_load_error", 32'(bus.load_error), 32'd0);
      checkOutput("rst_word_count", 32'(bus.word_count), 32'd0);
   endtask

   // Reference model: parse the frame in stim_q as a whole.
   task automatic computeExpected();
      int          pos;
      int          n;
      logic [7:0]  x;
      logic [7:0]  b;
      logic [31:0] w;
      exp_data.delete();
      exp_done  = 1'b0;
      exp_error = 1'b0;
      pos = 0;
      while (pos < stim_q.size() && stim_q[pos] != 8'hA5) pos++;
      n = int'(stim_q[pos+1]) + 256 * int'(stim_q[pos+2]);
      if (n > CAP) begin
         exp_error = 1'b1;
         return;
      end
      x = 8'd0;
      for (int i = 0; i < n; i++) begin
         w = 32'd0;
         for (int k = 0; k < 4; k++) begin
            b = stim_q[pos + 3 + 4*i + k];
            w = w | (32'(b) << (8*k));
            x = x ^ b;
         end
         exp_data.push_back(w);
      end
      if (stim_q[pos + 3 + 4*n] == x) exp_done = 1'b1;
      else                            exp_error = 1'b1;
   endtask

   // Send stim_q; random idle gaps up to max_gap, plus one forced gap of
   // gap_len cycles before byte gap_at.
   task automatic applyStimulus(input int max_gap, input int gap_at,
                                input int gap_len);
      int g;
      int t;
      for (int i = 0; i < stim_q.size(); i++) begin
         g = (max_gap > 0) ? $urandom_range(max_gap, 0) : 0;
         if (i == gap_at) g = gap_len;
         if (g > 0) begin
            bus.rx_valid = 1'b0;
            repeat (g) @(posedge clk);
            #1;
         end
         bus.rx_data  = stim_q[i];
         bus.rx_valid = 1'b1;
         t = 0;
         while (bus.rx_ready !== 1'b1 && t < 50) begin
            @(posedge clk);
            #1;
            t++;
         end
         if (t >= 50) begin
            checkOutput("rx_ready_wait", 32'd0, 32'd1);
            bus.rx_valid = 1'b0;
            return;
         end
         @(posedge clk);
         #1;
      end
      bus.rx_valid = 1'b0;
   endtask

   task automatic runFrameCheck(input string name, input int max_gap,
                                input int gap_at, input int gap_len);
      int n;
      $display("[TB] frame: %s (%0d bytes)", name, stim_q.size());
      computeExpected();
      got_addr.delete();
      got_data.delete();
      applyStimulus(max_gap, gap_at, gap_len);
      repeat (2) begin
         @(posedge clk);
         #1;
      end
      checkOutput("wr_count", 32'(got_data.size()), 32'(exp_data.size()));
      n = (got_data.size() < exp_data.size()) ? got_data.size() : exp_data.size();
      for (int i = 0; i < n; i++) begin
         checkOutput("wr_addr", 32'(got_addr[i]), 32'(i));
         checkOutput("wr_data", got_data[i], exp_data[i]);
      end
      checkOutput("word_count", 32'(bus.word_count), 32'(exp_data.size()));
      checkOutput("load_done",  32'(bus.load_done),  32'(exp_done));
      checkOutput("load_error", 32'(bus.load_error), 32'(exp_error));
      checkOutput("cpu_rst_n",  32'(bus.cpu_rst_n),  32'(exp_done));
      checkOutput("rx_ready_end", 32'(bus.rx_ready), 32'd0);
   endtask

   // Pulse restart from DONE/ERROR, optionally with a sync byte offered in
   // the same cycle (it must be refused).
   task automatic doRestart(input bit with_byte);
      bus.restart  = 1'b1;
      bus.rx_valid = with_byte;
      bus.rx_data  = 8'hA5;
      checkOutput("rx_ready_restart", 32'(bus.rx_ready), 32'd0);
      @(posedge clk);
      #1;
      bus.restart  = 1'b0;
      bus.rx_valid = 1'b0;
      checkOutput("restart_cpu_rst_n",  32'(bus.cpu_rst_n),  32'd0);
      checkOutput("restart_load_done",  32'(bus.load_done),  32'd0);
      checkOutput("restart_load_error", 32'(bus.load_error), 32'd0);
      checkOutput("restart_word_count", 32'(bus.word_count), 32'd0);
      checkOutput("restart_rx_ready",   32'(bus.rx_ready),   32'd1);
   endtask

   task automatic loadValidFrame(input logic [7:0] csum_byte);
      stim_q = '{8'hA5, 8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00,
                 8'h93, 8'h00, 8'h50, 8'h00, csum_byte};
   endtask

   task automatic buildRandomFrame(input bit full_size);
      int         ng;
      int         n;
      int         mode;
      logic [7:0] b;
      logic [7:0] x;
      stim_q.delete();
      ng = $urandom_range(3, 0);
      for (int i = 0; i < ng; i++) begin
         b = 8'($urandom_range(255, 0));
         if (b == 8'hA5) b = 8'h00;
         stim_q.push_back(b);
      end
      stim_q.push_back(8'hA5);
      mode = full_size ? 2 : $urandom_range(7, 0);
      if (mode == 0) begin
         n = $urandom_range(CAP + 8, CAP + 1);
         stim_q.push_back(8'(n));
         stim_q.push_back(8'(n >> 8));
         return;
      end
      n = full_size ? CAP : $urandom_range(CAP, 0);
      stim_q.push_back(8'(n));
      stim_q.push_back(8'(n >> 8));
      x = 8'd0;
      for (int i = 0; i < 4*n; i++) begin
         b = 8'($urandom_range(255, 0));
         stim_q.push_back(b);
         x = x ^ b;
      end
      if (mode == 1) x = x ^ 8'($urandom_range(255, 1));
      stim_q.push_back(x);
   endtask

   initial begin
      rst          = 1'b1;
      bus.rx_valid = 1'b0;
      bus.rx_data  = 8'h00;
      bus.restart  = 1'b0;

      #3;
      checkResetValues();
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      #1;
      checkOutput("idle_rx_ready", 32'(bus.rx_ready), 32'd1);

      loadValidFrame(8'hD0);
      runFrameCheck("valid 2-word", 0, -1, 0);

      doRestart(1'b1);
      loadValidFrame(8'hD0);
      runFrameCheck("restart + gap mid-word", 0, 5, 3);

      doRestart(1'b0);
      loadValidFrame(8'hD1);
      runFrameCheck("bad checksum", 0, -1, 0);

      doRestart(1'b0);
      stim_q = '{8'h00, 8'hFF, 8'hA5, 8'h00, 8'h00, 8'h00};
      runFrameCheck("garbage + zero length", 0, -1, 0);

      doRestart(1'b0);
      stim_q = '{8'hA5, 8'h11, 8'h00};
      runFrameCheck("oversize length", 0, -1, 0);

      // Async reset after six payload bytes, checked before any clock edge.
      doRestart(1'b0);
      stim_q = '{8'hA5, 8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00,
                 8'h93, 8'h00};
      applyStimulus(0, -1, 0);
      #2;
      rst = 1'b1;
      #1;
      checkResetValues();
      #3;
      rst = 1'b0;
      @(posedge clk);
      #1;
      loadValidFrame(8'hD0);
      runFrameCheck("valid after mid-load reset", 0, -1, 0);

      for (int it = 0; it < 10; it++) begin
         doRestart(1'($urandom_range(1, 0)));
         buildRandomFrame(it == 0);
         runFrameCheck("random", 2, -1, 0);
      end

      $display("%0d/%0d checks passed", pass_count, check_count);
      $finish;
   end

endmodule
